// File: rtl/password_checker_if.sv
// Keypad-side bundle for password_checker: digit strobes and controls in,
// light-controller drive (trueOut/falseOut/enable) out.
interface password_checker_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       clear;
  logic       new_pw;
  logic       trueOut;
  logic       falseOut;
  logic       enable;

  modport master (
    output digit_valid, digit, clear, new_pw,
    input  trueOut, falseOut, enable
  );

  modport slave (
    input  digit_valid, digit, clear, new_pw,
    output trueOut, falseOut, enable
  );
endinterface

// File: rtl/password_checker.sv
// BCD keypad password checker with consecutive-failure lockout and in-field
// password change; all outputs registered from the next state.
module password_checker #(
  parameter int unsigned           DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]   DEFAULT_PW  = 16'h1234,
  parameter int unsigned           MAX_FAIL    = 3,
  parameter int unsigned           LOCK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  password_checker_if.slave bus
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle, StEntry, StCheck, StPass, StFail, StLock, StNewpw
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    pw_q, pw_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic            true_q, false_q, en_q;

  logic            digit_ok;
  logic            fresh;
  logic [CW-1:0]   cnt_inc;
  logic [W-1:0]    shift_in;
  logic [FW-1:0]   fail_inc;

  always_comb begin
    digit_ok = bus.digit_valid && (bus.digit <= 4'd9);
    // IDLE and FAIL start a new entry rather than continuing one
    fresh    = (state_q == StIdle) || (state_q == StFail);
    cnt_inc  = fresh ? CW'(1) : cnt_q + CW'(1);
    shift_in = fresh ? W'(bus.digit) : W'({shift_q, bus.digit});
    fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    lock_d  = lock_q;

    unique case (state_q)
      StIdle, StFail, StEntry: begin
        if (bus.clear) begin
          state_d = StIdle;
          shift_d = '0;
          cnt_d   = '0;
        end else if (digit_ok) begin
          shift_d = shift_in;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CW'(DIGITS)) ? StCheck : StEntry;
        end
      end
      StCheck: begin
        shift_d = '0;
        cnt_d   = '0;
        if (bus.clear) begin
          state_d = StIdle;
        end else if (shift_q == pw_q) begin
          state_d = StPass;
          fail_d  = '0;
        end else begin
          fail_d  = fail_inc;
          if (fail_inc == FW'(MAX_FAIL)) begin
            state_d = StLock;
            lock_d  = LW'(LOCK_CYCLES - 1);
          end else begin
            state_d = StFail;
          end
        end
      end
      StPass: begin
        if (bus.clear) begin
          state_d = StIdle;
        end else if (bus.new_pw) begin
          state_d = StNewpw;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      StNewpw: begin
        if (bus.clear) begin
          state_d = StIdle;
          shift_d = '0;
          cnt_d   = '0;
        end else if (digit_ok) begin
          if (cnt_inc == CW'(DIGITS)) begin
            pw_d    = shift_in;
            state_d = StIdle;
            shift_d = '0;
            cnt_d   = '0;
          end else begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
          end
        end
      end
      StLock: begin
        if (lock_q == '0) begin
          state_d = StIdle;
          fail_d  = '0;
        end else begin
          lock_d  = lock_q - LW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      pw_q    <= DEFAULT_PW;
      cnt_q   <= '0;
      fail_q  <= '0;
      lock_q  <= '0;
      true_q  <= 1'b0;
      false_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      true_q  <= (state_d == StPass);
      false_q <= (state_d == StFail) || (state_d == StLock);
      en_q    <= (state_d == StEntry) || (state_d == StCheck) || (state_d == StNewpw);
    end
  end

  assign bus.trueOut  = true_q;
  assign bus.falseOut = false_q;
  assign bus.enable   = en_q;

endmodule

// File: doc/password_checker.md
PASSWORD_CHECKER -- requirements
Module: password_checker

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits in a password.
REQ-002 Parameter DEFAULT_PW, default 16'h1234: password loaded at reset, 4 bits per digit, first-entered digit in the MSBs.
REQ-003 Parameter MAX_FAIL, default 3: consecutive failed attempts that trigger lockout.
REQ-004 Parameter LOCK_CYCLES, default 16: lockout duration in clk cycles.
REQ-005 clk  input  1  rising-edge clock; the only clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 digit_valid  input  1  one-cycle strobe; digit is sampled when high.
REQ-008 digit  input  4  keypad digit; values 0-9 are valid.
REQ-009 clear  input  1  abort the current entry or result and return to IDLE.
REQ-010 new_pw  input  1  in PASS, start capture of a replacement password.
REQ-011 trueOut  output  1  password matched; drives the light controller's trueIn.
REQ-012 falseOut  output  1  password mismatch or lockout; drives the light controller's falseIn.
REQ-013 enable  output  1  entry or password capture in progress; drives the light controller's enable.

Function
REQ-014 States SHALL be IDLE, ENTRY, CHECK, PASS, FAIL, LOCK and NEWPW; all outputs SHALL be registered.
REQ-015 A digit_valid with digit > 9 SHALL be ignored in every state: no shift, no count change.
REQ-016 IDLE: a valid digit SHALL be shifted into the entry register, set the digit count to 1 and move to ENTRY; enable SHALL be 1 from the next edge.
REQ-017 ENTRY: each valid digit SHALL shift in; the edge accepting digit number DIGITS SHALL move to CHECK.
REQ-018 CHECK: one cycle with enable=1.
  - match: move to PASS, trueOut=1, fail count cleared.
  - mismatch: increment the fail count; move to LOCK if the new count equals MAX_FAIL, else to FAIL with falseOut=1.
REQ-019 Result latency SHALL be exactly 2 edges from the last accepted digit to trueOut/falseOut high.
REQ-020 PASS: trueOut SHALL stay 1 until clear or new_pw.
  - new_pw: move to NEWPW (enable=1, trueOut=0) with the digit count at 0.
  - clear and new_pw together: clear wins.
REQ-021 NEWPW: valid digits SHALL shift into the capture register; the edge accepting digit DIGITS SHALL write the stored password and move to IDLE.
REQ-022 clear in NEWPW SHALL abort the capture and keep the old password.
REQ-023 FAIL: falseOut SHALL stay 1 until clear (move to IDLE) or a valid digit (move to ENTRY as in REQ-016, falseOut=0).
REQ-024 LOCK: falseOut=1 and enable=0; a down-counter SHALL load LOCK_CYCLES-1 on entry.
  - digit_valid, clear and new_pw SHALL be ignored.
  - at count 0, the next edge SHALL move to IDLE and clear the fail count.
REQ-025 clear in ENTRY or CHECK SHALL discard the partial entry, move to IDLE and leave the fail count unchanged.
REQ-026 Same-cycle priority SHALL be: rst, then LOCK rules, then clear, then new_pw, then digit_valid.
REQ-027 trueOut, falseOut and enable SHALL be one-hot or all 0 in every cycle.
REQ-028 The fail count SHALL saturate at MAX_FAIL and never wrap.

Reset
REQ-029 rst high SHALL immediately force trueOut=0, falseOut=0, enable=0, state IDLE, entry register 0, digit count 0, fail count 0, lock counter 0, stored password DEFAULT_PW.
REQ-030 Reset asserted mid-entry, mid-NEWPW or in LOCK SHALL discard all progress and restore DEFAULT_PW.

Verification
REQ-031 Reset, then digits 1,2,3,4 -> enable=1 after the first digit; trueOut=1 exactly 2 edges after the digit 4; falseOut=0 throughout.
REQ-032 Digits 1,2,3,5 -> falseOut=1, fail count 1; then clear -> all outputs 0 in IDLE.
REQ-033 Three wrong entries -> LOCK with falseOut=1 for 16 cycles.
  - digits entered during LOCK are ignored.
  - then IDLE with fail count 0; digits 1,2,3,4 give trueOut=1.
REQ-034 PASS, new_pw, digits 9,8,7,6 -> IDLE.
  - digits 1,2,3,4 give falseOut=1.
  - digits 9,8,7,6 give trueOut=1.
REQ-035 Edge cases:
  - digit 4'hA mid-entry: no count change.
  - clear with digit_valid in the same cycle in ENTRY: IDLE, and the digit is dropped.
  - rst during NEWPW after 2 digits: outputs 0, and the password is 1234 again.
